// File: rtl/otter_ctrl_pkg.sv
// Shared types and constants for the OTTER multicycle control unit.
package otter_ctrl_pkg;

    typedef enum logic [6:0] {
        OpLui    = 7'b0110111,
        OpAuipc  = 7'b0010111,
        OpJal    = 7'b1101111,
        OpJalr   = 7'b1100111,
        OpBranch = 7'b1100011,
        OpLoad   = 7'b0000011,
        OpStore  = 7'b0100011,
        OpImm    = 7'b0010011,
        OpReg    = 7'b0110011,
        OpSystem = 7'b1110011
    } opcode_t;

    typedef enum logic [2:0] {
        StInit    = 3'd0,
        StFetch   = 3'd1,
        StExec    = 3'd2,
        StMemWait = 3'd3,
        StWrBk    = 3'd4,
        StIntr    = 3'd5
    } fsm_state_t;

    localparam logic [11:0] MRET_IMM    = 12'h302;
    localparam logic [2:0]  FUNCT3_PRIV = 3'b000;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/otter_wait_ctr.sv
// Loadable down-counter timing the INIT, FETCH and MEM_WAIT dwell periods.
module otter_wait_ctr #(
    parameter int unsigned W = 1
) (
    input  logic         CLK,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        cnt_q <= cnt_d;
    end

    assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/otter_mc_ctrl_fsm.sv
// OTTER RV32I multicycle control FSM. Define OTTER_ILLEGAL_TRAP_EN to trap
// unknown opcodes through the INTR state and expose ILL_TRAP.
module otter_mc_ctrl_fsm
    import otter_ctrl_pkg::*;
#(
    parameter int unsigned INIT_CYCLES = 1,
    parameter int unsigned IMEM_LAT    = 1,
    parameter int unsigned DMEM_LAT    = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] IR,
    input  logic        INTR,
    input  logic        INTR_EN,
`ifdef OTTER_ILLEGAL_TRAP_EN
    output logic        ILL_TRAP,
`endif
    output logic        SYS_RST,
    output logic        PC_WRITE,
    output logic        REG_WRITE,
    output logic        CSR_WRITE,
    output logic        MEM_RD1_EN,
    output logic        MEM_RD2_EN,
    output logic        MEM_WR2_EN,
    output logic        INT_TAKEN,
    output logic        MRET_EXEC
);

    localparam int unsigned CntW = $clog2(max3(INIT_CYCLES, IMEM_LAT, DMEM_LAT) + 1);

    fsm_state_t      state_q, state_d;
    logic            cnt_load, cnt_done;
    logic [CntW-1:0] cnt_val;
    logic            trap_req;
    opcode_t         opc;
    logic            unused_ir;

    assign opc       = opcode_t'(IR[6:0]);
    assign trap_req  = INTR && INTR_EN;
    assign unused_ir = ^{IR[19:15], IR[11:7]};

`ifdef OTTER_ILLEGAL_TRAP_EN
    logic ill_q, ill_d, illegal;
`endif

    otter_wait_ctr #(
        .W (CntW)
    ) u_wait_ctr (
        .CLK        (CLK),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .done_o     (cnt_done)
    );

    always_comb begin
        state_d    = state_q;
        SYS_RST    = 1'b0;
        PC_WRITE   = 1'b0;
        REG_WRITE  = 1'b0;
        CSR_WRITE  = 1'b0;
        MEM_RD1_EN = 1'b0;
        MEM_RD2_EN = 1'b0;
        MEM_WR2_EN = 1'b0;
        INT_TAKEN  = 1'b0;
        MRET_EXEC  = 1'b0;
`ifdef OTTER_ILLEGAL_TRAP_EN
        illegal    = 1'b0;
        ill_d      = 1'b0;
        ILL_TRAP   = 1'b0;
`endif
        case (state_q)
            StInit: begin
                SYS_RST = 1'b1;
                if (cnt_done) state_d = StFetch;
            end
            StFetch: begin
                MEM_RD1_EN = 1'b1;
                if (cnt_done) state_d = StExec;
            end
            StExec: begin
                case (opc)
                    OpLui, OpAuipc, OpJal, OpJalr, OpImm, OpReg: begin
                        PC_WRITE  = 1'b1;
                        REG_WRITE = 1'b1;
                    end
                    OpStore: begin
                        PC_WRITE   = 1'b1;
                        MEM_WR2_EN = 1'b1;
                    end
                    OpBranch: PC_WRITE = 1'b1;
                    OpLoad:   MEM_RD2_EN = 1'b1;
                    OpSystem: begin
                        PC_WRITE = 1'b1;
                        if (IR[14:12] != FUNCT3_PRIV) begin
                            REG_WRITE = 1'b1;
                            CSR_WRITE = 1'b1;
                        end else if (IR[31:20] == MRET_IMM) begin
                            MRET_EXEC = 1'b1;
                        end
                    end
                    default: begin
`ifdef OTTER_ILLEGAL_TRAP_EN
                        illegal = 1'b1;
`else
                        PC_WRITE = 1'b1;
`endif
                    end
                endcase
                if (opc == OpLoad) begin
                    state_d = (DMEM_LAT == 1) ? StWrBk : StMemWait;
`ifdef OTTER_ILLEGAL_TRAP_EN
                end else if (illegal) begin
                    state_d = StIntr;
                    ill_d   = 1'b1;
`endif
                end else begin
                    state_d = trap_req ? StIntr : StFetch;
                end
            end
            StMemWait: begin
                MEM_RD2_EN = 1'b1;
                if (cnt_done) state_d = StWrBk;
            end
            StWrBk: begin
                PC_WRITE  = 1'b1;
                REG_WRITE = 1'b1;
                state_d   = trap_req ? StIntr : StFetch;
            end
            StIntr: begin
                INT_TAKEN = 1'b1;
                PC_WRITE  = 1'b1;
`ifdef OTTER_ILLEGAL_TRAP_EN
                ILL_TRAP  = ill_q;
`endif
                state_d   = StFetch;
            end
            default: state_d = StInit;
        endcase

        // Reset overrides every decode in the same cycle.
        if (RST) begin
            state_d    = StInit;
            SYS_RST    = 1'b1;
            PC_WRITE   = 1'b0;
            REG_WRITE  = 1'b0;
            CSR_WRITE  = 1'b0;
            MEM_RD1_EN = 1'b0;
            MEM_RD2_EN = 1'b0;
            MEM_WR2_EN = 1'b0;
            INT_TAKEN  = 1'b0;
            MRET_EXEC  = 1'b0;
`ifdef OTTER_ILLEGAL_TRAP_EN
            ill_d      = 1'b0;
            ILL_TRAP   = 1'b0;
`endif
        end
    end

    always_comb begin
        cnt_load = RST || (state_d != state_q);
        case (state_d)
            StInit:    cnt_val = CntW'(INIT_CYCLES);
            StFetch:   cnt_val = CntW'(IMEM_LAT);
            StMemWait: cnt_val = CntW'(DMEM_LAT - 1);
            default:   cnt_val = CntW'(1);
        endcase
    end

    always_ff @(posedge CLK) begin
        state_q <= state_d;
`ifdef OTTER_ILLEGAL_TRAP_EN
        ill_q   <= ill_d;
`endif
    end

endmodule

// File: doc/otter_mc_ctrl_fsm.md
Name: otter_mc_ctrl_fsm

Overview:
- Parametrised multicycle control unit for the OTTER RV32I core.
- Sequences reset, fetch, execute, data-memory wait, write-back and interrupt entry.
- Supports configurable instruction/data memory latency and a configurable reset pulse length.
- Adds SYSTEM-opcode decode (CSR writes, MRET) and precise interrupt entry at instruction boundaries. It drives datapath write enables and memory strobes only; no datapath state lives here.

Parameters:
- INIT_CYCLES, 1, number of cycles SYS_RST is held after reset (>=1).
- IMEM_LAT, 1, cycles MEM_RD1_EN is held per instruction fetch (>=1).
- DMEM_LAT, 1, cycles MEM_RD2_EN is held per load (>=1).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- IR  in  32  current instruction, valid from first EXEC cycle.
- INTR  in  1  external interrupt request, level.
- INTR_EN  in  1  mstatus.MIE from CSR file.
- SYS_RST  out  1  datapath reset pulse.
- PC_WRITE  out  1  PC register load enable.
- REG_WRITE  out  1  register file write enable.
- CSR_WRITE  out  1  CSR file write enable.
- MEM_RD1_EN  out  1  instruction memory read strobe.
- MEM_RD2_EN  out  1  data memory read strobe.
- MEM_WR2_EN  out  1  data memory write strobe.
- INT_TAKEN  out  1  trap entry: PC <= mtvec, save mepc, clear MIE.
- MRET_EXEC  out  1  MRET: PC <= mepc, restore MIE.

Behaviour:
- Reset is synchronous, active-high, on clock CLK.
- All outputs are combinational decodes of PS, IR and the wait counter; no registered outputs.
- While RST=1: SYS_RST=1, all other outputs 0. On the next edge PS<=INIT and the counter is loaded.
- States: INIT, FETCH, EXEC, MEM_WAIT, WR_BK, INTR. A single down-counter of width $clog2(max(INIT_CYCLES,IMEM_LAT,DMEM_LAT)+1) is loaded on each state entry.
- INIT: SYS_RST=1 for INIT_CYCLES cycles, then go to FETCH.
- FETCH: MEM_RD1_EN=1 for IMEM_LAT cycles, then go to EXEC.
- EXEC: one cycle, decoded on IR[6:0]:
  - R/I/JAL/JALR/LUI/AUIPC: PC_WRITE=1, REG_WRITE=1.
  - Store: PC_WRITE=1, MEM_WR2_EN=1. Stores are always single-cycle.
  - Branch: PC_WRITE=1.
  - Load: MEM_RD2_EN=1, no PC_WRITE. Go to WR_BK if DMEM_LAT=1, else MEM_WAIT.
  - SYSTEM with func3!=0 (CSR ops): PC_WRITE=1, REG_WRITE=1, CSR_WRITE=1.
  - SYSTEM with func3=0 and IR[31:20]=12'h302: PC_WRITE=1, MRET_EXEC=1.
  - Other SYSTEM encodings (ECALL/EBREAK): PC_WRITE=1 only, as a NOP.
  - Unknown opcode: PC_WRITE=1 only (NOP), unless ILLEGAL_TRAP_EN is defined.
- MEM_WAIT: MEM_RD2_EN=1 for DMEM_LAT-1 cycles, then go to WR_BK.
- WR_BK: PC_WRITE=1, REG_WRITE=1; one cycle.
- Instruction completion is the EXEC cycle for non-loads and the WR_BK cycle for loads. At completion, if INTR&&INTR_EN the next state is INTR, else FETCH.
- INTR: INT_TAKEN=1, PC_WRITE=1 for one cycle, then go to FETCH.
- Interrupts are never taken mid-instruction. INTR asserted during FETCH or MEM_WAIT waits for completion. INTR deasserted before completion is not taken.
- MRET completing with INTR&&INTR_EN: MRET_EXEC asserts in EXEC, then INTR follows. Because INTR_EN is sampled combinationally, the datapath's MIE value at that cycle decides.
- Latency: non-load = IMEM_LAT+1 cycles; load = IMEM_LAT+DMEM_LAT+1; trap adds 1.
- Illegal PS encodings return to INIT.

Optional Feature:
- Macro: OTTER_ILLEGAL_TRAP_EN.
- Defined: adds output ILL_TRAP (1 bit). An unknown opcode in EXEC asserts no write enables and moves to INTR. INTR asserts INT_TAKEN=1, PC_WRITE=1 and ILL_TRAP=1, regardless of INTR_EN.
- Undefined: the ILL_TRAP port is absent; unknown opcodes are NOPs (PC_WRITE only).

Decomposition:
- Package otter_ctrl_pkg:
  - opcode_t enum (adds SYSTEM=7'b1110011).
  - fsm_state_t enum.
  - MRET_IMM=12'h302.
  - FUNCT3_PRIV=3'b000.
- Sub-module otter_wait_ctr: loadable down-counter with a done flag (cnt==1); handles the INIT, FETCH and MEM_WAIT dwell times.

Test Plan:
- Reset, defaults: RST high 2 cycles, then low → SYS_RST high exactly 1 cycle after RST drops; MEM_RD1_EN high 1 cycle; EXEC next.
- ADDI (0x00500093), IMEM_LAT=3 → MEM_RD1_EN high 3 cycles; then PC_WRITE and REG_WRITE high 1 cycle; period 4 cycles.
- LW (0x0000A103), DMEM_LAT=2 → EXEC and MEM_WAIT with MEM_RD2_EN high 2 cycles total, no PC_WRITE; then WR_BK with PC_WRITE=REG_WRITE=1.
- INTR=1, INTR_EN=1 raised during FETCH of an ADD → ADD completes with REG_WRITE; next cycle INT_TAKEN=PC_WRITE=1; then FETCH. Repeat with INTR_EN=0 → no INT_TAKEN.
- MRET (0x30200073) and CSRRW (0x34011073) → MRET: MRET_EXEC=PC_WRITE=1, CSR_WRITE=0. CSRRW: CSR_WRITE=REG_WRITE=PC_WRITE=1.
- RST asserted during MEM_WAIT → same cycle all outputs 0 except SYS_RST=1; INIT sequence restarts. With OTTER_ILLEGAL_TRAP_EN, IR=0xFFFFFFFF → INTR state with ILL_TRAP=1.
